// File: rtl/audio_i2s_pkg.sv
// rtl/audio_i2s_pkg.sv - shared I2S frame constants and transmitter state type
package audio_i2s_pkg;
    localparam int SLOT_BITS = 32;
    localparam int FRAME_BCK = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_t;
endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - stereo-pair sample queue with registered ready and level
module audio_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             ready,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      level_next;

    // Push is gated by the registered ready, so a same-cycle pop never frees a slot early.
    assign do_push = push && ready;
    assign do_pop  = pop && !empty;
    assign empty   = (level == '0);
    assign rdata   = mem[rptr];

    always_comb begin
        level_next = level;
        case ({do_push, do_pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ready <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            level <= level_next;
            ready <= (level_next < (AW+1)'(DEPTH));
        end
    end
endmodule

// File: rtl/i2s_tx_master.sv
// rtl/i2s_tx_master.sv - I2S master transmitter; I2S_TX_MONO_EN sends the left sample in both slots
module i2s_tx_master
    import audio_i2s_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_left,
    input  logic [DATA_W-1:0]             s_right,
    output logic                          bck,
    output logic                          lck,
    output logic                          din,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_M1    = CW'(CLK_DIV / 2 - 1);
    localparam logic [5:0]    POS_LAST   = 6'(FRAME_BCK - 1);
    localparam logic [5:0]    POS_R_PREV = 6'(SLOT_BITS - 1);

    i2s_state_t             state;
    logic [CW-1:0]          bck_cnt;
    logic [5:0]             pos;
    logic [FRAME_BCK-1:0]   sreg;
    logic                   dly;
    logic                   fall_tick;
    logic                   frame_start;
    logic                   pop;
    logic                   fifo_empty;
    logic [2*DATA_W-1:0]    head;
    logic [DATA_W-1:0]      left_src;
    logic [DATA_W-1:0]      right_src;
    logic [SLOT_BITS-1:0]   left_slot;
    logic [SLOT_BITS-1:0]   right_slot;
    logic [FRAME_BCK-1:0]   frame_bits;

    audio_sample_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .wdata ({s_left, s_right}),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .ready (s_ready),
        .level (fifo_level)
    );

    assign left_src = head[2*DATA_W-1 -: DATA_W];
`ifdef I2S_TX_MONO_EN
    assign right_src = left_src;
`else
    assign right_src = head[DATA_W-1:0];
`endif

    // Samples are left-justified in their 32-bit slots; unused low bits stay zero.
    assign left_slot  = SLOT_BITS'(left_src) << (SLOT_BITS - DATA_W);
    assign right_slot = SLOT_BITS'(right_src) << (SLOT_BITS - DATA_W);
    assign frame_bits = fifo_empty ? '0 : {left_slot, right_slot};

    // pos idles at the last frame position so the first fall tick in RUN is a frame boundary.
    assign fall_tick   = (state == RUN) && (bck_cnt == CNT_LAST);
    assign frame_start = fall_tick && (pos == POS_LAST) && enable;
    assign pop         = frame_start && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bck_cnt  <= '0;
            pos      <= POS_LAST;
            sreg     <= '0;
            dly      <= 1'b0;
            bck      <= 1'b0;
            lck      <= 1'b0;
            din      <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    bck_cnt <= '0;
                    pos     <= POS_LAST;
                    dly     <= 1'b0;
                    bck     <= 1'b0;
                    lck     <= 1'b0;
                    din     <= 1'b0;
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (fall_tick) begin
                        bck_cnt <= '0;
                        bck     <= 1'b0;
                        if (pos == POS_LAST) begin
                            if (!enable) begin
                                state <= IDLE;
                                lck   <= 1'b0;
                                din   <= 1'b0;
                                dly   <= 1'b0;
                            end else begin
                                // dly provides the one-BCK I2S delay across slot and frame edges.
                                pos      <= '0;
                                lck      <= 1'b0;
                                din      <= dly;
                                dly      <= frame_bits[FRAME_BCK-1];
                                sreg     <= {frame_bits[FRAME_BCK-2:0], 1'b0};
                                underrun <= fifo_empty;
                            end
                        end else begin
                            pos  <= pos + 1'b1;
                            lck  <= (pos >= POS_R_PREV);
                            din  <= dly;
                            dly  <= sreg[FRAME_BCK-1];
                            sreg <= {sreg[FRAME_BCK-2:0], 1'b0};
                        end
                    end else begin
                        bck_cnt <= bck_cnt + 1'b1;
                        bck     <= (bck_cnt >= HALF_M1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_tx_master.sv
// tb/tb_i2s_tx_master.sv - randomized model-checked bench for i2s_tx_master
module tb_i2s_tx_master;
    localparam int DW = 16;
    localparam int CD = 4;
    localparam int FD = 4;
    localparam int LW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_left = '0;
    logic [DW-1:0] s_right = '0;
    logic          s_ready;
    logic          bck;
    logic          lck;
    logic          din;
    logic          underrun;
    logic [LW-1:0] fifo_level;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    i2s_tx_master #(
        .DATA_W     (DW),
        .CLK_DIV    (CD),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_left     (s_left),
        .s_right    (s_right),
        .bck        (bck),
        .lck        (lck),
        .din        (din),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    // Reference: a queue of pairs and a time-since-start counter; slot timing is pure arithmetic.
    logic [2*DW-1:0] q[$];
    bit              m_run = 0;
    bit              m_ready = 0;
    bit              m_und = 0;
    bit              m_prev = 0;
    logic [63:0]     m_stream = '0;
    int              m_t = 0;
    bit              chk_en = 0;

    function automatic logic [63:0] make_stream(input logic [2*DW-1:0] pair);
        logic [63:0]   s;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        s = '0;
        l = pair[2*DW-1 -: DW];
        r = pair[DW-1:0];
`ifdef I2S_TX_MONO_EN
        r = l;
`endif
        s[63 -: DW] = l;
        s[31 -: DW] = r;
        return s;
    endfunction

    always @(posedge clk) begin
        bit boundary;
        boundary = 0;
        m_und = 0;
        if (rst) begin
            m_run = 0;
            q.delete();
            m_ready = 0;
            m_prev = 0;
            m_t = 0;
        end else begin
            boundary = m_run && (m_t % CD == CD - 1) && ((m_t / CD) % 64 == 0);
            if (boundary && !enable) begin
                m_run = 0;
            end else if (boundary) begin
                m_prev = (m_t / CD == 0) ? 1'b0 : m_stream[0];
                if (q.size() > 0) begin
                    m_stream = make_stream(q.pop_front());
                end else begin
                    m_stream = '0;
                    m_und = 1;
                end
                m_t++;
            end else if (m_run) begin
                m_t++;
            end else if (enable) begin
                m_run = 1;
                m_t = 0;
            end
            if (s_valid && m_ready) q.push_back({s_left, s_right});
            m_ready = (q.size() < FD);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [4+LW:0] e;
            logic [4+LW:0] g;
            int b;
            int p;
            bit eb;
            bit el;
            bit ed;
            eb = 0;
            el = 0;
            ed = 0;
            if (m_run) begin
                b  = m_t / CD;
                eb = (m_t % CD) >= CD / 2;
                if (b > 0) begin
                    p  = (b - 1) % 64;
                    el = (p >= 32);
                    ed = (p == 0) ? m_prev : m_stream[64 - p];
                end
            end
            e = {eb, el, ed, m_und, m_ready, LW'(q.size())};
            g = {bck, lck, din, underrun, s_ready, fifo_level};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL model_cycle t=%0t got=%b exp=%b (bck lck din und rdy lvl)", $time, g, e);
            end
        end
    end

    logic prev_bck_n = 1'b0;
    int   rise_cnt = 0;
    always @(negedge clk) begin
        if (bck && !prev_bck_n) rise_cnt++;
        prev_bck_n = bck;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        tick();
        s_valid = 1'b0;
    endtask

    // Collects din at bck rises 3..66 and lck at rises 2..65 counted from enable.
    task automatic capture(output logic [63:0] dbits, output logic [63:0] lbits, output int gap);
        int   k;
        int   n;
        int   last_rise;
        logic pb;
        k = 0;
        n = 0;
        last_rise = 0;
        gap = 0;
        pb = bck;
        dbits = '0;
        lbits = '0;
        while (k < 66 && n < 400) begin
            tick();
            n++;
            if (bck && !pb) begin
                k++;
                if (k == 2) gap = n - last_rise;
                last_rise = n;
                if (k >= 2 && k <= 65) lbits[65 - k] = lck;
                if (k >= 3) dbits[66 - k] = din;
            end
            pb = bck;
        end
        check("capture_timeout", 64'(k), 64'd66);
    endtask

    initial begin
        logic [63:0] dbits;
        logic [63:0] lbits;
        logic [63:0] mono_exp;
        int gap;
        int n;
        int r0;
        int per_mille;

        tick();
        chk_en = 1;
        tick();
        tick();
        check("reset_outputs", {60'd0, bck, lck, din, underrun}, 64'd0);
        check("reset_level", 64'(fifo_level), 64'd0);
        check("reset_ready", 64'(s_ready), 64'd0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", 64'(s_ready), 64'd1);

        push_pair(16'hA5A5, 16'h5A5A);
        enable = 1'b1;
        capture(dbits, lbits, gap);
        check("stereo_din", dbits, 64'hA5A5_0000_5A5A_0000);
        check("stereo_lck", lbits, 64'h0000_0000_FFFF_FFFF);
        check("bck_period", 64'(gap), 64'(CD));
        enable = 1'b0;
        repeat (300) tick();

`ifdef I2S_TX_MONO_EN
        mono_exp = 64'h8001_0000_8001_0000;
`else
        mono_exp = 64'h8001_0000_7FFF_0000;
`endif
        push_pair(16'h8001, 16'h7FFF);
        enable = 1'b1;
        capture(dbits, lbits, gap);
        check("slot_content_8001", dbits, mono_exp);
        enable = 1'b0;
        repeat (300) tick();

        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_left  = DW'(16'h1000 + i);
            s_right = DW'(16'h2000 + i);
            tick();
        end
        s_valid = 1'b0;
        check("full_level", 64'(fifo_level), 64'd4);
        check("full_ready", 64'(s_ready), 64'd0);
        enable = 1'b1;
        r0 = rise_cnt;
        n = 0;
        while (fifo_level == LW'(4) && n < 20) begin
            tick();
            n++;
        end
        check("first_pop_latency", 64'(n), 64'd5);
        check("level_after_pop", 64'(fifo_level), 64'd3);
        check("ready_after_pop", 64'(s_ready), 64'd1);
        repeat (42) tick();
        enable = 1'b0;
        repeat (300) tick();
        check("rises_until_stop", 64'(rise_cnt - r0), 64'd65);
        check("stopped_outputs", {61'd0, bck, lck, din}, 64'd0);
        check("stopped_level", 64'(fifo_level), 64'd3);

        enable = 1'b1;
        n = 0;
        while (!lck && n < 600) begin
            tick();
            n++;
        end
        check("right_slot_reached", 64'(lck), 64'd1);
        repeat (20) tick();
        rst = 1'b1;
        enable = 1'b0;
        tick();
        check("midframe_rst_outputs", {60'd0, bck, lck, din, underrun}, 64'd0);
        check("midframe_rst_level", 64'(fifo_level), 64'd0);
        rst = 1'b0;
        tick();
        check("ready_after_release", 64'(s_ready), 64'd1);

        enable = 1'b1;
        n = 0;
        while (!underrun && n < 300) begin
            tick();
            n++;
        end
        check("underrun_seen", 64'(underrun), 64'd1);
        tick();
        check("underrun_width", 64'(underrun), 64'd0);
        gap = 1;
        while (!underrun && gap < 400) begin
            tick();
            gap++;
        end
        check("underrun_period", 64'(gap), 64'd256);
        enable = 1'b0;
        repeat (300) tick();

        for (int i = 0; i < 3000; i++) begin
            per_mille = (i < 1500) ? 400 : 3;
            s_valid = ($urandom_range(0, 999) < per_mille);
            s_left  = DW'($urandom);
            s_right = DW'($urandom);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            rst = ($urandom_range(0, 1499) == 0);
            tick();
        end
        rst = 1'b0;
        s_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2s_tx_master.md
I2S_TX_MASTER -- requirements
Module: i2s_tx_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width per channel (16..32).
REQ-002 SHALL have parameter CLK_DIV, default 4, clk cycles per BCK period (even, >=2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, stereo-pair entries (power of 2, >=2).
REQ-004 clk  in  1  system clock; sole clock domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  run request for the serial output.
REQ-007 s_valid  in  1  stereo pair offered.
REQ-008 s_ready  out  1  pair accepted when s_valid && s_ready.
REQ-009 s_left  in  DATA_W  left sample, two's complement.
REQ-010 s_right  in  DATA_W  right sample, two's complement.
REQ-011 bck  out  1  I2S bit clock to DAC BCK.
REQ-012 lck  out  1  word select to DAC LCK; 0 = left, 1 = right.
REQ-013 din  out  1  serial data to DAC DIN, MSB first.
REQ-014 underrun  out  1  one-clk pulse when a frame starts with the FIFO empty.
REQ-015 fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.

Function
REQ-016 SHALL generate BCK from counter bck_cnt 0..CLK_DIV-1: bck=0 for bck_cnt<CLK_DIV/2, else 1; "fall tick" = bck_cnt wrap to 0.
REQ-017 lck and din SHALL change only on fall ticks; the DAC samples on the BCK rising edge.
REQ-018 Frame = 64 BCK: 32-bit left slot (lck=0), then 32-bit right slot (lck=1).
REQ-019 I2S format: sample MSB on din one BCK after the lck transition; bits beyond DATA_W SHALL be 0; last slot bit carries the LSB of the preceding slot's 1-BCK delay chain.
REQ-020 FSM states IDLE, RUN. IDLE: bck=0, lck=0, din=0, bck_cnt held 0.
REQ-021 IDLE->RUN when enable=1; first fall tick begins frame with lck=0.
REQ-022 RUN->IDLE only at frame end (after right-slot bit 31) when enable=0; mid-frame enable drop completes the frame.
REQ-023 Pair SHALL be popped at the fall tick starting each frame; if FIFO empty, frame sends all zeros and underrun pulses for exactly one clk.
REQ-024 s_ready = (fifo_level < FIFO_DEPTH); no push when full, even if a pop occurs that cycle.
REQ-025 Push and pop in the same clk on an empty FIFO: pop sees empty (no bypass), underrun fires, pushed pair stored.
REQ-026 Simultaneous push and pop when partially full: fifo_level unchanged.
REQ-027 FIFO SHALL accept pushes in IDLE; pops occur only in RUN.
REQ-028 Minimum push-to-first-MSB latency: one BCK after the next frame start.

Reset
REQ-029 While rst=1: state IDLE, FIFO empty, bck=0, lck=0, din=0, underrun=0, fifo_level=0, s_ready=0.
REQ-030 s_ready SHALL be 1 in the first clk after rst deasserts.
REQ-031 rst mid-frame SHALL abort immediately; in-flight and queued samples discarded.

Configuration
REQ-032 Macro I2S_TX_MONO_EN defined: s_right ignored, right slot carries the popped s_left value (center-channel DAC use).
REQ-033 Macro undefined: left and right slots carry s_left and s_right respectively.

Structure
REQ-034 Package audio_i2s_pkg SHALL hold SLOT_BITS=32, FRAME_BCK=64 and the FSM state enum.
REQ-035 FIFO SHALL be sub-module audio_sample_fifo (width 2*DATA_W, depth FIFO_DEPTH, level output).

Verification
REQ-036 Default params, push L=16'hA5A5 R=16'h5A5A, enable=1 -> din left slot 1010010110100101 then 16 zeros, right slot 0101101001011010 then zeros, MSB 1 BCK after lck edge, bck period 4 clk.
REQ-037 enable=1, no pushes -> every frame all-zero din, underrun one-clk pulse per frame (every 256 clk).
REQ-038 Push 4 pairs in IDLE -> fifo_level=4, s_ready=0; 5th s_valid not accepted; after first frame start fifo_level=3, s_ready=1.
REQ-039 enable dropped at left-slot bit 10 -> frame completes through right-slot bit 31, then bck/lck/din held 0.
REQ-040 rst asserted mid right slot -> next clk all outputs 0, fifo_level=0; s_ready=1 one clk after release.
REQ-041 I2S_TX_MONO_EN defined, push L=16'h8001 R=16'h7FFF -> both slots carry 1000000000000001.
